// File: rtl/simon_pkt_arbiter.sv
// Round-robin arbiter sharing one SIMON packet core between two requesters.
// Snapshots the granted packet, sequences load/encrypt/read, and aborts stalls via a watchdog.
module simon_pkt_arbiter #(
  parameter int PKT_BYTES = 34,
  parameter int TIMEOUT   = 1024
) (
  input  logic                            clk,
  input  logic                            R,
  input  logic [1:0]                      ch_newPKT,
  input  logic [1:0][PKT_BYTES*8-1:0]     ch_in,
  output logic [1:0]                      ch_loadPKT,
  output logic [1:0]                      ch_donePKT,
  output logic [1:0]                      ch_outValid,
  input  logic [1:0]                      ch_readPKT,
  output logic [PKT_BYTES*8-1:0]          ch_out,
  output logic                            core_newPKT,
  output logic [PKT_BYTES*8-1:0]          core_in,
  input  logic                            core_loadPKT,
  input  logic                            core_donePKT,
  input  logic                            core_outDone,
  output logic                            core_readPKT,
  input  logic [PKT_BYTES*8-1:0]          core_out,
  output logic                            owner,
  output logic                            busy,
  output logic                            timeout
);

  localparam int WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} stateT;

  stateT                  stateReg, stateNext;
  logic                   ownerReg;
  logic                   lastReg;
  logic [WDW-1:0]         wdogReg;
  logic [PKT_BYTES*8-1:0] coreInReg;
  logic                   donePulseReg;
  logic                   timeoutReg;

  logic anyReq;
  logic grantCh;
  logic wdogExpire;
  logic ownerRead;

  assign anyReq    = |ch_newPKT;
  // On a tie the channel that did not win last time is served.
  assign grantCh   = (&ch_newPKT) ? ~lastReg : ch_newPKT[1];
  assign ownerRead = ch_readPKT[ownerReg];

  always_comb begin
    stateNext  = stateReg;
    wdogExpire = 1'b0;
    case (stateReg)
      IDLE: if (anyReq) stateNext = LOAD;
      LOAD: begin
        if (core_donePKT) begin
          stateNext = RUN;
        end else if (wdogReg == WDW'(TIMEOUT - 1)) begin
          wdogExpire = 1'b1;
          stateNext  = IDLE;
        end
      end
      RUN: begin
        if (core_outDone) begin
          stateNext = DRAIN;
        end else if (wdogReg == WDW'(TIMEOUT - 1)) begin
          wdogExpire = 1'b1;
          stateNext  = IDLE;
        end
      end
      DRAIN: if (ownerRead) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      stateReg     <= IDLE;
      ownerReg     <= 1'b0;
      lastReg      <= 1'b1;
      wdogReg      <= '0;
      coreInReg    <= '0;
      donePulseReg <= 1'b0;
      timeoutReg   <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      donePulseReg <= (stateReg == LOAD) && core_donePKT;
      timeoutReg   <= wdogExpire;
      if (stateReg == IDLE && anyReq) begin
        ownerReg  <= grantCh;
        lastReg   <= grantCh;
        coreInReg <= ch_in[grantCh];
        wdogReg   <= '0;
      end else if (stateReg == LOAD && core_donePKT) begin
        wdogReg <= '0;
      end else if (stateReg == LOAD || stateReg == RUN) begin
        wdogReg <= wdogReg + WDW'(1);
      end
    end
  end

  assign busy         = (stateReg != IDLE);
  assign core_newPKT  = (stateReg == LOAD);
  assign core_readPKT = (stateReg == DRAIN) && ownerRead;
  assign core_in      = coreInReg;
  assign ch_out       = core_out;
  assign owner        = ownerReg;
  assign timeout      = timeoutReg;

  // Per-channel strobes are only ever routed to the current owner.
  for (genvar gi = 0; gi < 2; gi++) begin : gChan
    logic isOwner;
    assign isOwner         = (ownerReg == 1'(gi));
    assign ch_loadPKT[gi]  = busy && isOwner && core_loadPKT;
    assign ch_donePKT[gi]  = donePulseReg && isOwner;
    assign ch_outValid[gi] = (stateReg == DRAIN) && isOwner;
  end

endmodule

// File: tb/tb_simon_pkt_arbiter.sv
// Self-checking bench for simon_pkt_arbiter: table-driven transactions with a result
// scoreboard, plus watchdog-abort and mid-transaction reset sequences.
module tb_simon_pkt_arbiter;
  localparam int PB = 34;
  localparam int W  = PB * 8;
  localparam int TO = 16;
  localparam logic [W-1:0] KEY = {17{16'hA5C3}};

  logic                clk = 1'b0;
  logic                R;
  logic [1:0]          newPkt, readPkt;
  logic [1:0][W-1:0]   chIn;
  logic                coreLoad, coreDone, coreOutDone;
  logic [W-1:0]        coreOut;
  logic [1:0]          ch_loadPKT, ch_donePKT, ch_outValid;
  logic [W-1:0]        ch_out, core_in;
  logic                core_newPKT, core_readPKT, owner, busy, timeout;

  always #5 clk = ~clk;

  simon_pkt_arbiter #(.PKT_BYTES(PB), .TIMEOUT(TO)) dut (
    .clk(clk), .R(R),
    .ch_newPKT(newPkt), .ch_in(chIn),
    .ch_loadPKT(ch_loadPKT), .ch_donePKT(ch_donePKT), .ch_outValid(ch_outValid),
    .ch_readPKT(readPkt), .ch_out(ch_out),
    .core_newPKT(core_newPKT), .core_in(core_in),
    .core_loadPKT(coreLoad), .core_donePKT(coreDone), .core_outDone(coreOutDone),
    .core_readPKT(core_readPKT), .core_out(coreOut),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  typedef struct {
    logic         owner;
    logic [W-1:0] pkt;
  } expT;

  typedef struct {
    logic [1:0] req;
    int         doneDly;
    int         outDly;
    logic       expOwner;
  } vecT;

  expT sbq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chkW(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 16; i++) r[i*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  task automatic checkReset(input string tag);
    chk({tag, "_busy"},       32'(busy), 0);
    chk({tag, "_newPKT"},     32'(core_newPKT), 0);
    chk({tag, "_readPKT"},    32'(core_readPKT), 0);
    chk({tag, "_donePKT"},    32'(ch_donePKT), 0);
    chk({tag, "_outValid"},   32'(ch_outValid), 0);
    chk({tag, "_loadPKT"},    32'(ch_loadPKT), 0);
    chk({tag, "_timeout"},    32'(timeout), 0);
    chk({tag, "_owner"},      32'(owner), 0);
    chkW({tag, "_core_in"},   core_in, '0);
  endtask

  // Request already driven in IDLE; grant happens at the next edge.
  task automatic serve(input int doneDly, input int outDly);
    expT        e;
    int         o;
    logic [1:0] oh;
    cyc();
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got 0 entries expected at least 1");
      return;
    end
    e  = sbq[0];
    o  = int'(e.owner);
    oh = 2'b01 << o;
    chk("grant_busy", 32'(busy), 1);
    chk("grant_newPKT", 32'(core_newPKT), 1);
    chk("grant_owner", 32'(owner), 32'(e.owner));
    chk("timeout_low", 32'(timeout), 0);
    chkW("core_in_snap", core_in, e.pkt);
    chIn[o]  = ~chIn[o];
    coreLoad = 1'b1;
    #1;
    chk("ch_loadPKT", 32'(ch_loadPKT), 32'(oh));
    for (int i = 0; i < doneDly; i++) cyc();
    coreDone = 1'b1;
    cyc();
    coreDone  = 1'b0;
    coreLoad  = 1'b0;
    newPkt[o] = 1'b0;
    chk("donePKT_pulse", 32'(ch_donePKT), 32'(oh));
    chk("newPKT_drop", 32'(core_newPKT), 0);
    chk("no_timeout_load", 32'(timeout), 0);
    for (int i = 0; i < outDly; i++) cyc();
    coreOut     = core_in ^ KEY;
    coreOutDone = 1'b1;
    cyc();
    coreOutDone = 1'b0;
    chk("donePKT_once", 32'(ch_donePKT), 0);
    chk("outValid", 32'(ch_outValid), 32'(oh));
    chk("no_timeout_run", 32'(timeout), 0);
    chk("readPKT_idle", 32'(core_readPKT), 0);
    chkW("core_in_hold", core_in, e.pkt);
    chkW("ch_out", ch_out, e.pkt ^ KEY);
    readPkt = ~oh;
    #1;
    chk("nonowner_read", 32'(core_readPKT), 0);
    cyc();
    chk("drain_hold", 32'(ch_outValid), 32'(oh));
    readPkt = oh;
    #1;
    chk("owner_read", 32'(core_readPKT), 1);
    cyc();
    readPkt = 2'b00;
    chk("busy_after_read", 32'(busy), 0);
    chk("outValid_clear", 32'(ch_outValid), 0);
    void'(sbq.pop_front());
    $display("txn owner=%0d done_dly=%0d out_dly=%0d result=%0h", o, doneDly, outDly, ch_out);
  endtask

  initial begin
    vecT tbl[8];
    int  tcnt;

    tbl[0] = '{2'b11, 0,  0,  1'b0};
    tbl[1] = '{2'b11, 1,  2,  1'b1};
    tbl[2] = '{2'b11, 2,  0,  1'b0};
    tbl[3] = '{2'b11, 0,  5,  1'b1};
    tbl[4] = '{2'b01, 3,  10, 1'b0};
    tbl[5] = '{2'b10, 15, 15, 1'b1};
    tbl[6] = '{2'b11, 15, 0,  1'b0};
    tbl[7] = '{2'b11, 4,  15, 1'b1};

    R = 1'b1; newPkt = 2'b00; readPkt = 2'b00;
    coreLoad = 1'b0; coreDone = 1'b0; coreOutDone = 1'b0; coreOut = '0;
    chIn[0] = rnd(); chIn[1] = rnd();
    cyc();
    cyc();
    checkReset("reset");
    R = 1'b0;

    for (int i = 0; i < 8; i++) begin
      chIn[0] = rnd();
      chIn[1] = rnd();
      newPkt  = tbl[i].req;
      sbq.push_back('{tbl[i].expOwner, chIn[tbl[i].expOwner]});
      serve(tbl[i].doneDly, tbl[i].outDly);
    end

    // Watchdog: ch0 wins the tie, core never finishes, ch1 is served afterwards.
    chIn[0] = rnd();
    chIn[1] = rnd();
    newPkt  = 2'b11;
    sbq.push_back('{1'b1, chIn[1]});
    cyc();
    chk("wd_owner", 32'(owner), 0);
    coreDone = 1'b1;
    cyc();
    coreDone  = 1'b0;
    newPkt[0] = 1'b0;
    tcnt = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (timeout === 1'b1) begin
        tcnt = k;
        break;
      end
    end
    chk("wd_cycles", 32'(tcnt), 16);
    chk("wd_idle", 32'(busy), 0);
    chk("wd_newPKT", 32'(core_newPKT), 0);
    serve(2, 3);

    // Reset in RUN after a ch0 grant: the following tie must still go to ch0.
    chIn[0] = rnd();
    newPkt  = 2'b01;
    cyc();
    chk("rst_pre_owner", 32'(owner), 0);
    coreDone = 1'b1;
    cyc();
    coreDone = 1'b0;
    newPkt   = 2'b00;
    cyc();
    R = 1'b1;
    cyc();
    R = 1'b0;
    checkReset("midrun");
    chIn[0] = rnd();
    chIn[1] = rnd();
    newPkt  = 2'b11;
    sbq.push_back('{1'b0, chIn[0]});
    serve(1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
